// File: rtl/hpdl_write_sequencer.sv
// Dirty-tracked shadow buffer that writes only changed glyphs to four cascaded HPDL-1414 displays.
// Optional cursor caret blink is compiled in when HPDL_CARET_EN is defined.
module hpdl_write_sequencer #(
    parameter int unsigned SETUP_CYC  = 2,
    parameter int unsigned STROBE_CYC = 4,
    parameter int unsigned HOLD_CYC   = 2,
    parameter int unsigned BLINK_CYC  = 6000000,
    parameter logic [6:0]  CARET_CHAR = 7'h5F
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_wr_valid,
    output logic       o_wr_ready,
    input  logic [3:0] i_wr_addr,
    input  logic [6:0] i_wr_data,
    input  logic       i_clear,
    input  logic [3:0] i_cursor,
    output logic [6:0] o_hpdl_d,
    output logic [1:0] o_hpdl_a,
    output logic [3:0] o_hpdl_wr_n,
    output logic       o_busy
);
    typedef enum logic [1:0] {StIdle, StSetup, StStrobe, StHold} state_e;

    state_e      state_q;
    logic [6:0]  shadow_q [16];
    logic [6:0]  shadow_d [16];
    logic [15:0] dirty_q, dirty_d;
    logic [3:0]  rr_ptr_q, pos_q, last_cursor_q;
    logic [15:0] cnt_q;
    logic [6:0]  d_q;
    logic [1:0]  a_q;
    logic [3:0]  wr_n_q;
    logic        accept, sel_found, blink_tick, phase;
    logic [3:0]  sel_p;
    logic [6:0]  sel_char, wr_char;

    assign o_wr_ready  = ~i_clear;
    assign accept      = i_wr_valid & ~i_clear;
    assign o_hpdl_d    = d_q;
    assign o_hpdl_a    = a_q;
    assign o_hpdl_wr_n = wr_n_q;
    assign o_busy      = (|dirty_q) || (state_q != StIdle);

`ifdef HPDL_CARET_EN
    logic [31:0] blink_cnt_q;
    logic        phase_q;

    assign blink_tick = (blink_cnt_q == 32'(BLINK_CYC - 1));
    assign phase      = phase_q;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            blink_cnt_q <= '0;
            phase_q     <= 1'b0;
        end else if (blink_tick) begin
            blink_cnt_q <= '0;
            phase_q     <= ~phase_q;
        end else begin
            blink_cnt_q <= blink_cnt_q + 32'd1;
        end
    end
`else
    logic unused_blink;

    assign unused_blink = ^BLINK_CYC;
    assign blink_tick   = 1'b0;
    assign phase        = 1'b0;
`endif

    assign sel_char = (phase && sel_p == i_cursor) ? CARET_CHAR : shadow_q[sel_p];

    // Control codes show as blanks; lower case folds onto the upper-case glyphs.
    always_comb begin
        if (i_wr_data < 7'h20) begin
            wr_char = 7'h20;
        end else if (i_wr_data >= 7'h60) begin
            wr_char = i_wr_data - 7'h20;
        end else begin
            wr_char = i_wr_data;
        end
    end

    // Round-robin search for the first dirty position at or after rr_ptr.
    always_comb begin
        logic [3:0] idx;
        idx       = '0;
        sel_found = 1'b0;
        sel_p     = rr_ptr_q;
        for (int i = 0; i < 16; i++) begin
            idx = rr_ptr_q + 4'(i);
            if (!sel_found && dirty_q[idx]) begin
                sel_found = 1'b1;
                sel_p     = idx;
            end
        end
    end

    // Clearing the selected bit comes first so a same-cycle set wins.
    always_comb begin
        dirty_d  = dirty_q;
        shadow_d = shadow_q;
        if (state_q == StIdle && sel_found) begin
            dirty_d[sel_p] = 1'b0;
        end
        if (i_cursor != last_cursor_q) begin
            dirty_d[last_cursor_q] = 1'b1;
            dirty_d[i_cursor]      = 1'b1;
        end
        if (blink_tick) begin
            dirty_d[i_cursor] = 1'b1;
        end
        if (accept) begin
            dirty_d[i_wr_addr]  = 1'b1;
            shadow_d[i_wr_addr] = wr_char;
        end
        if (i_clear) begin
            dirty_d = '1;
            for (int i = 0; i < 16; i++) begin
                shadow_d[i] = 7'h20;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            dirty_q       <= '1;
            last_cursor_q <= '0;
            for (int i = 0; i < 16; i++) begin
                shadow_q[i] <= 7'h20;
            end
        end else begin
            dirty_q       <= dirty_d;
            last_cursor_q <= i_cursor;
            shadow_q      <= shadow_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q  <= StIdle;
            rr_ptr_q <= '0;
            pos_q    <= '0;
            cnt_q    <= '0;
            d_q      <= 7'h20;
            a_q      <= 2'b11;
            wr_n_q   <= 4'hF;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (sel_found) begin
                        pos_q   <= sel_p;
                        d_q     <= sel_char;
                        a_q     <= ~sel_p[1:0];
                        cnt_q   <= '0;
                        state_q <= StSetup;
                    end
                end
                StSetup: begin
                    if (cnt_q == 16'(SETUP_CYC - 1)) begin
                        cnt_q   <= '0;
                        wr_n_q  <= ~(4'b0001 << pos_q[3:2]);
                        state_q <= StStrobe;
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                StStrobe: begin
                    if (cnt_q == 16'(STROBE_CYC - 1)) begin
                        cnt_q   <= '0;
                        wr_n_q  <= 4'hF;
                        state_q <= StHold;
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                StHold: begin
                    if (cnt_q == 16'(HOLD_CYC - 1)) begin
                        cnt_q    <= '0;
                        rr_ptr_q <= pos_q + 4'd1;
                        state_q  <= StIdle;
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end
endmodule

// File: tb/tb_hpdl_write_sequencer.sv
// Self-checking bench: a transaction-level model of the dirty/round-robin write rules is
// compared against the pins every cycle, plus directed checks of the main scenarios.
module tb_hpdl_write_sequencer;
    localparam int SETUP_CYC  = 2;
    localparam int STROBE_CYC = 4;
    localparam int HOLD_CYC   = 2;
    localparam int BLINK_CYC  = 20;
    localparam int TOT        = SETUP_CYC + STROBE_CYC + HOLD_CYC;

    logic       clk = 1'b0, rst_n = 1'b0, wr_valid = 1'b0, clear = 1'b0;
    logic [3:0] wr_addr = '0, cursor = '0;
    logic [6:0] wr_data = '0;
    logic       wr_ready, busy;
    logic [6:0] hpdl_d;
    logic [1:0] hpdl_a;
    logic [3:0] hpdl_wr_n;

    int checks = 0, errors = 0, strobe_cyc = 0;

    always #5 clk = ~clk;

    hpdl_write_sequencer #(
        .SETUP_CYC (SETUP_CYC),
        .STROBE_CYC(STROBE_CYC),
        .HOLD_CYC  (HOLD_CYC),
        .BLINK_CYC (BLINK_CYC),
        .CARET_CHAR(7'h5F)
    ) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_wr_valid (wr_valid),
        .o_wr_ready (wr_ready),
        .i_wr_addr  (wr_addr),
        .i_wr_data  (wr_data),
        .i_clear    (clear),
        .i_cursor   (cursor),
        .o_hpdl_d   (hpdl_d),
        .o_hpdl_a   (hpdl_a),
        .o_hpdl_wr_n(hpdl_wr_n),
        .o_busy     (busy)
    );

    // Reference model: m_k is the cycle index inside the current glyph write, -1 when idle.
    logic [6:0]  m_shadow [16] = '{default: 7'h20};
    logic [15:0] m_dirty = 16'hFFFF;
    int          m_k = -1, m_rr = 0, m_p = 0, m_last = 0, m_cnt = 0;
    bit          m_phase = 1'b0;
    logic [6:0]  m_d = 7'h20;
    logic [1:0]  m_a = 2'b11;

    function automatic logic [6:0] fold(input logic [6:0] c);
        if (c < 7'd32) return 7'd32;
        if (c >= 7'd96) return c - 7'd32;
        return c;
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) m_shadow[i] = 7'h20;
            m_dirty = 16'hFFFF; m_k = -1; m_rr = 0; m_last = 0; m_cnt = 0; m_phase = 1'b0;
            m_d = 7'h20; m_a = 2'b11;
        end else begin
            if (m_k >= 0) begin
                if (m_k == TOT - 1) begin
                    m_k  = -1;
                    m_rr = (m_p + 1) % 16;
                end else begin
                    m_k++;
                end
            end else if (m_dirty != 0) begin
                for (int i = 0; i < 16; i++) begin
                    if (m_dirty[(m_rr + i) % 16]) begin
                        m_p = (m_rr + i) % 16;
                        break;
                    end
                end
                m_dirty[m_p] = 1'b0;
                m_d = (m_phase && m_p == int'(cursor)) ? 7'h5F : m_shadow[m_p];
                m_a = 2'(3 - (m_p % 4));
                m_k = 0;
            end
`ifdef HPDL_CARET_EN
            if (m_cnt == BLINK_CYC - 1) begin
                m_cnt = 0;
                m_phase = !m_phase;
                m_dirty[cursor] = 1'b1;
            end else begin
                m_cnt++;
            end
`endif
            if (int'(cursor) != m_last) begin
                m_dirty[m_last] = 1'b1;
                m_dirty[cursor] = 1'b1;
                m_last = int'(cursor);
            end
            if (wr_valid && !clear) begin
                m_dirty[wr_addr]  = 1'b1;
                m_shadow[wr_addr] = fold(wr_data);
            end
            if (clear) begin
                m_dirty = 16'hFFFF;
                for (int i = 0; i < 16; i++) m_shadow[i] = 7'h20;
            end
        end
    end

    function automatic logic [3:0] exp_wr_n();
        if (m_k >= SETUP_CYC && m_k < SETUP_CYC + STROBE_CYC) return 4'hF ^ (4'b1 << (m_p / 4));
        return 4'hF;
    endfunction

    function automatic int strobe_pos();
        int c = 0;
        for (int i = 0; i < 4; i++) if (!hpdl_wr_n[i]) c = i;
        return c * 4 + (3 - int'(hpdl_a));
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
        chk("wr_n", hpdl_wr_n, exp_wr_n());
        chk("d", hpdl_d, m_d);
        chk("a", hpdl_a, m_a);
        chk("busy", busy, (m_dirty != 0) || (m_k >= 0));
        chk("ready", wr_ready, !clear);
        if (hpdl_wr_n != 4'hF) strobe_cyc++;
    endtask

    task automatic wait_strobe(input string tag, output int n);
        n = 0;
        while (hpdl_wr_n == 4'hF && n < 40) begin
            cyc();
            n++;
        end
        chk(tag, hpdl_wr_n != 4'hF, 1'b1);
    endtask

    task automatic wait_strobe_end();
        for (int i = 0; i < 40 && hpdl_wr_n != 4'hF; i++) cyc();
    endtask

    task automatic wait_idle(input string tag, input int max);
        for (int i = 0; i < max && busy; i++) cyc();
        chk(tag, busy, 1'b0);
    endtask

    task automatic write1(input logic [3:0] addr, input logic [6:0] data);
        wr_valid = 1'b1; wr_addr = addr; wr_data = data;
        cyc();
        wr_valid = 1'b0;
    endtask

    initial begin
        int n;
        #20_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        repeat (3) cyc();
        chk("rst_wr_n", hpdl_wr_n, 4'hF);
        chk("rst_d", hpdl_d, 7'h20);
        chk("rst_a", hpdl_a, 2'b11);
        chk("rst_busy", busy, 1'b1);
        chk("rst_ready", wr_ready, 1'b1);
        rst_n = 1'b1;
        strobe_cyc = 0;
`ifndef HPDL_CARET_EN
        wait_idle("boot_idle", 300);
        chk("boot_strobes", 16'(strobe_cyc), 16'(16 * STROBE_CYC));

        write1(4'd5, 7'h61);
        wait_strobe("w5_strobe", n);
        chk("w5_latency", 16'(n), 16'(SETUP_CYC + 1));
        chk("w5_wr_n", hpdl_wr_n, 4'b1101);
        chk("w5_d", hpdl_d, 7'h41);
        chk("w5_a", hpdl_a, 2'b10);
        wait_idle("w5_idle", 50);

        // Position 9 leaves rr_ptr at 10 while 3 and 14 wait.
        write1(4'd9, 7'h39);
        write1(4'd3, 7'h33);
        write1(4'd14, 7'h45);
        wait_strobe("rr_a", n);
        chk("rr_first", 16'(strobe_pos()), 16'd9);
        wait_strobe_end();
        wait_strobe("rr_b", n);
        chk("rr_second", 16'(strobe_pos()), 16'd14);
        wait_strobe_end();
        wait_strobe("rr_c", n);
        chk("rr_third", 16'(strobe_pos()), 16'd3);
        wait_idle("rr_idle", 50);

        write1(4'd7, 7'h41);
        wait_strobe("p7_strobe", n);
        write1(4'd7, 7'h42);
        wait_strobe_end();
        chk("p7_hold_d", hpdl_d, 7'h41);
        wait_strobe("p7_again", n);
        chk("p7_pos", 16'(strobe_pos()), 16'd7);
        chk("p7_d", hpdl_d, 7'h42);
        wait_idle("p7_idle", 50);

        write1(4'd15, 7'h21);
        wait_idle("p15_idle", 50);
        strobe_cyc = 0;
        clear = 1'b1; wr_valid = 1'b1; wr_addr = 4'd0; wr_data = 7'h5A;
        #1 chk("clr_ready", wr_ready, 1'b0);
        cyc();
        clear = 1'b0;
        cyc();
        wr_valid = 1'b0;
        wait_idle("clr_idle", 400);
        chk("clr_strobes", 16'(strobe_cyc), 16'(17 * STROBE_CYC));

        strobe_cyc = 0;
        cursor = 4'd2;
        cyc();
        wait_idle("cur_idle", 100);
        chk("cur_strobes", 16'(strobe_cyc), 16'(2 * STROBE_CYC));
        strobe_cyc = 0;
        repeat (100) cyc();
        chk("no_blink", 16'(strobe_cyc), 16'd0);

        write1(4'd1, 7'h31);
        wait_strobe("mid_strobe", n);
        rst_n = 1'b0;
        cyc();
        chk("rst_mid_wr_n", hpdl_wr_n, 4'hF);
        rst_n = 1'b1;
        wait_idle("rst_mid_idle", 300);
`else
        cursor = 4'd2;
        write1(4'd2, 7'h41);
        repeat (300) cyc();
`endif
        for (int i = 0; i < 400; i++) begin
            wr_valid = ($urandom % 3) == 0;
            wr_addr  = 4'($urandom);
            wr_data  = 7'($urandom);
            clear    = ($urandom % 40) == 0;
            if ($urandom % 25 == 0) cursor = 4'($urandom);
            cyc();
        end
        wr_valid = 1'b0;
        clear    = 1'b0;
`ifndef HPDL_CARET_EN
        wait_idle("rand_idle", 600);
`else
        repeat (200) cyc();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/hpdl_write_sequencer.md
Name: hpdl_write_sequencer

Overview:
- Owns a 16-character shadow buffer for four cascaded HPDL-1414 displays (4 digits each).
- Writes to the glass only positions marked dirty, with programmable setup, strobe and hold phases on the data, address and WR_n lines.
- Accepts character writes from the UART side and a cursor position; optionally blinks a caret at the cursor.
- Sits between the UART/line-edit logic and the HPDL pins, and replaces the free-running address-scan refresh.

Parameters:
- SETUP_CYC, 2, cycles with addr/data stable and WR_n high before the strobe (min 1).
- STROBE_CYC, 4, cycles WR_n is held low (min 1).
- HOLD_CYC, 2, cycles addr/data held after WR_n rises (min 1).
- BLINK_CYC, 6000000, cycles per caret phase (0.5 s at 12 MHz).
- CARET_CHAR, 7'h5F, glyph shown at the cursor during the caret phase.

Ports:
- i_clk  in  1  system clock, 12 MHz.
- i_rst_n  in  1  synchronous active-low reset.
- i_wr_valid  in  1  host write request.
- o_wr_ready  out  1  write accepted when i_wr_valid && o_wr_ready.
- i_wr_addr  in  4  display position 0..15 (0 = leftmost of chip 0).
- i_wr_data  in  7  ASCII character.
- i_clear  in  1  single-cycle pulse: fill the whole buffer with spaces.
- i_cursor  in  4  caret position.
- o_hpdl_d  out  7  HPDL D6..D0.
- o_hpdl_a  out  2  HPDL A1..A0.
- o_hpdl_wr_n  out  4  per-chip WR_n, active low.
- o_busy  out  1  high when any position is dirty or the FSM is not in IDLE.

Behaviour:
- Clocking and reset: one clock. All state is reset synchronously while i_rst_n=0.
- Reset values:
  - shadow[0..15]=7'h20; dirty=16'hFFFF, so the display is blanked after reset.
  - FSM=IDLE; rr_ptr=0; o_hpdl_wr_n=4'hF; o_hpdl_d=7'h20; o_hpdl_a=2'b11.
  - o_wr_ready=1; o_busy=1; blink counter=0; caret phase=0; last_cursor=0.
- Reset asserted mid-strobe: o_hpdl_wr_n is 4'hF after the next edge.
- Host write:
  - Accepted on a cycle with i_wr_valid && o_wr_ready.
  - Next edge: shadow[i_wr_addr] and dirty[i_wr_addr] are both updated (dirty set).
- Character mapping at accept:
  - 0x20..0x5F stored as-is.
  - 0x60..0x7F stored minus 0x20 (upper-cased).
  - 0x00..0x1F stored as 0x20.
- Clear:
  - i_clear=1 sets all shadow entries to 0x20 and dirty=16'hFFFF on the next edge.
  - o_wr_ready=0 in any cycle where i_clear=1. A write in that cycle is not accepted; the host holds it.
- FSM states IDLE, SETUP, STROBE, HOLD:
  - IDLE, when any dirty bit is set: select position p = first dirty position at or after rr_ptr, wrapping 15->0.
    - Clear dirty[p]; latch o_hpdl_d = disp(p) and o_hpdl_a = ~p[1:0]; set chip = p[3:2]; go to SETUP.
    - If a host write or caret event sets dirty[p] in the same cycle, the set wins and p is rewritten later.
  - SETUP: SETUP_CYC cycles, WR_n all high, then go to STROBE.
  - STROBE: o_hpdl_wr_n[chip]=0 for STROBE_CYC cycles, then go to HOLD.
  - HOLD: WR_n all high, addr/data unchanged for HOLD_CYC cycles. Then rr_ptr = p+1 (mod 16) and go to IDLE.
- o_hpdl_d and o_hpdl_a change only on the IDLE->SETUP transition. A host write to p during SETUP/STROBE/HOLD does not disturb the pins.
- Only one WR_n bit is ever low, and never outside STROBE.
- Latency:
  - Write accepted at cycle t: dirty set at t+1, SETUP entered at t+2 (when idle and p is first in round-robin order), WR_n low at t+2+SETUP_CYC.
  - One glyph occupies 1+SETUP_CYC+STROBE_CYC+HOLD_CYC cycles; the default is 9.
- disp(p) = CARET_CHAR when the caret is enabled, p==i_cursor and phase=1; otherwise shadow[p].
- Cursor tracking: when i_cursor != last_cursor, set dirty on both the old and the new position, then update last_cursor.
- o_busy is combinational: |dirty || state!=IDLE.

Optional Feature:
- Macro HPDL_CARET_EN.
- Defined:
  - The blink counter counts to BLINK_CYC-1, wraps, toggles phase, and sets dirty[i_cursor] on each toggle.
  - disp() applies the caret substitution.
- Undefined:
  - No blink counter; phase is held at 0 and disp(p)=shadow[p].
  - Cursor changes still mark both the old and new positions dirty.

Test Plan:
- Reset release -> 16 write cycles at positions 0..15 in order; each has WR_n low for 4 cycles on chip p>>2, d=0x20, a=~p[1:0]; then o_busy=0.
- Write addr 5 data 0x61 after idle -> SETUP 2 cycles later; o_hpdl_wr_n=4'b1101 for 4 cycles, a=2'b10, d=0x41.
- Writes to addr 3 then addr 14 in consecutive cycles with rr_ptr=10 -> 14 is strobed before 3.
- Write addr 7 = 0x42 while position 7 is in STROBE with 0x41 -> the pins keep 0x41 through HOLD, then a second write of 0x42 to position 7 follows.
- i_clear together with i_wr_valid -> o_wr_ready=0 that cycle, 16 space writes follow, and the held write completes afterwards.
- HPDL_CARET_EN with BLINK_CYC=20, cursor 2, shadow[2]=0x41 -> position 2 is rewritten alternately with 0x5F and 0x41 every 20 cycles; with the macro undefined, no rewrites occur.
